// File: rtl/phase_nco.sv
// rtl/phase_nco.sv - phase accumulator NCO with byte-serial tuning-word loader
//
// Purpose: accumulates a tuning word (ftw) every enabled cycle and presents the
// top PHASE_W accumulator bits to a sine lookup. The tuning word is loaded one
// byte at a time, LSB byte first, into a staging register and committed to ftw
// only after a complete word has arrived.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous active-high reset
//   en         accumulate enable
//   phase_clr  synchronous accumulator clear (overrides en)
//   cfg_data   tuning-word byte, LSB byte first
//   cfg_valid  cfg_data valid
//   cfg_ready  loader accepts a byte (low only during COMMIT)
//   cfg_abort  discard a partially loaded word (ignored during COMMIT)
//   phase_out  top PHASE_W bits of the accumulator
//   wrap       one-cycle pulse after an accumulator carry-out
//   ftw_busy   a load is in progress

module phase_nco #(
   parameter int ACC_W   = 24,
   parameter int PHASE_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               phase_clr,
   input  logic [7:0]         cfg_data,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic               cfg_abort,
   output logic [PHASE_W-1:0] phase_out,
   output logic               wrap,
   output logic               ftw_busy
);

   localparam int NB    = ACC_W / 8;
   // One extra code so byte_cnt can sit at NB while COMMIT is pending.
   localparam int CNT_W = $clog2(NB + 1);

   typedef enum logic {
      LOAD   = 1'b0,
      COMMIT = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_byte_cnt;
   logic [ACC_W-1:0]   r_stage;
   logic [ACC_W-1:0]   r_ftw;
   logic [ACC_W-1:0]   r_acc;
   logic               r_wrap;
   logic [ACC_W:0]     w_sum;
   logic               w_accept;
   logic               w_last;

   assign w_last = (r_byte_cnt == CNT_W'(NB - 1));

   // Loader FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Loader FSM: next state and handshake. Abort beats a byte presented in
   // the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      cfg_ready   = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         LOAD: begin
            cfg_ready = 1'b1;
            w_accept  = cfg_valid && !cfg_abort;
            if (w_accept && w_last) begin
               w_state_nxt = COMMIT;
            end
         end
         COMMIT: begin
            w_state_nxt = LOAD;
         end
         default: begin
            w_state_nxt = LOAD;
         end
      endcase
   end

   // Loader datapath: staging bytes, byte counter and committed tuning word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byte_cnt <= '0;
         r_stage    <= '0;
         r_ftw      <= '0;
      end else if (r_state == COMMIT) begin
         r_ftw      <= r_stage;
         r_byte_cnt <= '0;
      end else if (cfg_abort) begin
         r_byte_cnt <= '0;
      end else if (w_accept) begin
         for (int b = 0; b < NB; b++) begin
            if (CNT_W'(b) == r_byte_cnt) begin
               r_stage[b*8 +: 8] <= cfg_data;
            end
         end
         r_byte_cnt <= r_byte_cnt + 1'b1;
      end
   end

   // Extra top bit of the sum is the carry-out that drives wrap.
   assign w_sum = {1'b0, r_acc} + {1'b0, r_ftw};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc  <= '0;
         r_wrap <= 1'b0;
      end else if (phase_clr) begin
         r_acc  <= '0;
         r_wrap <= 1'b0;
      end else if (en) begin
         r_acc  <= w_sum[ACC_W-1:0];
         r_wrap <= w_sum[ACC_W];
      end else begin
         r_wrap <= 1'b0;
      end
   end

   assign phase_out = r_acc[ACC_W-1 -: PHASE_W];
   assign wrap      = r_wrap;
   assign ftw_busy  = (r_byte_cnt != '0) || (r_state == COMMIT);

endmodule

// File: tb/tb_phase_nco.sv
// tb/tb_phase_nco.sv - scoreboard bench for phase_nco

module tb_phase_nco;

   logic       clk;
   logic       rst;
   logic       en;
   logic       phase_clr;
   logic [7:0] cfg_data;
   logic       cfg_valid;
   logic       cfg_ready;
   logic       cfg_abort;
   logic [7:0] phase_out;
   logic       wrap;
   logic       ftw_busy;

   phase_nco #(.ACC_W(24), .PHASE_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .phase_clr (phase_clr),
      .cfg_data  (cfg_data),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_abort (cfg_abort),
      .phase_out (phase_out),
      .wrap      (wrap),
      .ftw_busy  (ftw_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] phase;
      logic       wrap;
      logic       ready;
      logic       busy;
   } exp_t;

   exp_t q_exp[$];

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [23:0] m_acc;
   logic [23:0] m_ftw;
   logic [23:0] m_stage;
   int          m_cnt;
   bit          m_commit;
   bit          m_wrap;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_acc    = '0;
      m_ftw    = '0;
      m_stage  = '0;
      m_cnt    = 0;
      m_commit = 0;
      m_wrap   = 0;
   endtask

   // Drive one cycle of inputs, predict the post-edge outputs, then compare.
   task automatic step(input logic i_en, input logic i_clr, input logic i_valid,
                       input logic [7:0] i_data, input logic i_abort);
      logic [24:0] s;
      exp_t        e;
      exp_t        got;
      en        = i_en;
      phase_clr = i_clr;
      cfg_valid = i_valid;
      cfg_data  = i_data;
      cfg_abort = i_abort;

      s = {1'b0, m_acc} + {1'b0, m_ftw};
      if (i_clr) begin
         m_acc  = '0;
         m_wrap = 0;
      end else if (i_en) begin
         m_acc  = s[23:0];
         m_wrap = s[24];
      end else begin
         m_wrap = 0;
      end

      if (m_commit) begin
         m_ftw    = m_stage;
         m_cnt    = 0;
         m_commit = 0;
      end else if (i_abort) begin
         m_cnt = 0;
      end else if (i_valid) begin
         m_stage[m_cnt*8 +: 8] = i_data;
         m_cnt++;
         if (m_cnt == 3) m_commit = 1;
      end

      e.phase = m_acc[23:16];
      e.wrap  = m_wrap;
      e.ready = !m_commit;
      e.busy  = (m_cnt != 0) || m_commit;
      q_exp.push_back(e);

      @(posedge clk);
      #1;
      if (q_exp.size() == 0) begin
         check_eq("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = q_exp.pop_front();
         got.phase = phase_out;
         got.wrap  = wrap;
         got.ready = cfg_ready;
         got.busy  = ftw_busy;
         check_eq("phase_out", {24'd0, got.phase}, {24'd0, e.phase});
         check_eq("wrap",      {31'd0, got.wrap},  {31'd0, e.wrap});
         check_eq("cfg_ready", {31'd0, got.ready}, {31'd0, e.ready});
         check_eq("ftw_busy",  {31'd0, got.busy},  {31'd0, e.busy});
      end
   endtask

   task automatic idle(input logic i_en, input logic i_clr, input int n);
      for (int i = 0; i < n; i++) step(i_en, i_clr, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic load_word(input logic i_en, input logic i_clr, input logic [23:0] w);
      logic [23:0] t;
      t = w;
      for (int i = 0; i < 3; i++) step(i_en, i_clr, 1'b1, t[i*8 +: 8], 1'b0);
   endtask

   initial begin
      rst       = 1'b1;
      en        = 1'b0;
      phase_clr = 1'b0;
      cfg_data  = 8'h00;
      cfg_valid = 1'b0;
      cfg_abort = 1'b0;
      model_reset();

      #12;
      check_eq("rst_phase", {24'd0, phase_out}, 32'h0);
      check_eq("rst_wrap",  {31'd0, wrap},      32'h0);
      check_eq("rst_ready", {31'd0, cfg_ready}, 32'h1);
      check_eq("rst_busy",  {31'd0, ftw_busy},  32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 00,00,01 LSB first: ftw = 0x010000, phase steps by one per cycle
      load_word(1'b1, 1'b0, 24'h010000);
      idle(1'b1, 1'b0, 6);
      check_eq("step_phase_lit", {24'd0, phase_out}, 32'h05);

      // hold with en=0
      idle(1'b0, 1'b0, 3);
      check_eq("hold_phase_lit", {24'd0, phase_out}, 32'h05);

      // clear overrides en
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      check_eq("clr_phase_lit", {24'd0, phase_out}, 32'h00);
      idle(1'b1, 1'b0, 2);

      // half-scale word: alternating phase with wrap on return to 0
      step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      load_word(1'b0, 1'b1, 24'h800000);
      idle(1'b0, 1'b1, 1);
      idle(1'b1, 1'b0, 6);

      // full-scale word, loaded while stopped and cleared
      load_word(1'b0, 1'b1, 24'hFFFFFF);
      idle(1'b0, 1'b1, 1);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      check_eq("ff_wrap0_lit", {31'd0, wrap}, 32'h0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      check_eq("ff_wrap1_lit", {31'd0, wrap}, 32'h1);
      idle(1'b1, 1'b0, 4);

      // partial word, abort, then abort racing a valid byte, then full word
      step(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0);
      step(1'b0, 1'b1, 1'b1, 8'hBB, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b1, 1'b1, 8'hCC, 1'b1);
      load_word(1'b0, 1'b1, 24'h001234);
      // byte presented during COMMIT must be ignored
      step(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      idle(1'b1, 1'b0, 4);

      // abort during COMMIT is ignored
      load_word(1'b1, 1'b0, 24'h020000);
      step(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
      idle(1'b1, 1'b0, 3);

      // async reset mid-load, between edges
      step(1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
      cfg_valid = 1'b1;
      cfg_data  = 8'h22;
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_phase", {24'd0, phase_out}, 32'h0);
      check_eq("arst_wrap",  {31'd0, wrap},      32'h0);
      check_eq("arst_ready", {31'd0, cfg_ready}, 32'h1);
      check_eq("arst_busy",  {31'd0, ftw_busy},  32'h0);
      model_reset();
      cfg_valid = 1'b0;
      #2;
      rst = 1'b0;
      idle(1'b1, 1'b0, 4);
      check_eq("post_rst_phase_lit", {24'd0, phase_out}, 32'h0);

      check_eq("scoreboard_drained", q_exp.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/phase_nco.md
PHASE_NCO -- requirements
Module: phase_nco

Interface
REQ-001 SHALL have parameter ACC_W, default 24, accumulator width in bits (ACC_W >= 16, multiple of 8).
REQ-002 SHALL have parameter PHASE_W, default 8, output phase width; phase is acc[ACC_W-1 -: PHASE_W].
REQ-003 SHALL have one clock, clk, and asynchronous active-high reset, rst.
REQ-004 Port `clk`, input, width 1: rising-edge clock for all state.
REQ-005 Port `rst`, input, width 1: asynchronous active-high reset.
REQ-006 Port `en`, input, width 1: accumulate enable.
REQ-007 Port `phase_clr`, input, width 1: synchronous accumulator clear.
REQ-008 Port `cfg_data`, input, width 8: tuning-word byte, LSB byte first.
REQ-009 Port `cfg_valid`, input, width 1: cfg_data valid.
REQ-010 Port `cfg_ready`, output, width 1: loader accepts a byte.
REQ-011 Port `cfg_abort`, input, width 1: discard a partially loaded word.
REQ-012 Port `phase_out`, output, width PHASE_W: phase to the sine lookup.
REQ-013 Port `wrap`, output, width 1: one-cycle pulse on accumulator overflow.
REQ-014 Port `ftw_busy`, output, width 1: a load is in progress.

Function
REQ-015 Accumulator update SHALL be acc <= (acc + ftw) mod 2^ACC_W on each rising edge with en=1 and phase_clr=0.
REQ-016 With en=0 and phase_clr=0, acc SHALL hold and wrap SHALL be 0.
REQ-017 phase_clr=1 SHALL set acc to 0 and wrap to 0, overriding en in the same cycle.
REQ-018 wrap SHALL be registered: 1 for exactly the cycle after an edge whose addition produced a carry-out of bit ACC_W-1, otherwise 0.
REQ-019 phase_out SHALL be the top PHASE_W bits of the acc register (no extra pipeline stage), so it changes one edge after the addition.
REQ-020 The loader FSM SHALL have exactly two states: LOAD and COMMIT.
REQ-021 In LOAD, cfg_ready SHALL be 1, and each edge with cfg_valid=1 SHALL write cfg_data into staging byte byte_cnt and increment byte_cnt.
REQ-022 Acceptance of byte ACC_W/8-1 SHALL move the FSM to COMMIT.
REQ-023 COMMIT SHALL last exactly one cycle with cfg_ready=0; on its closing edge ftw <= staging, byte_cnt <= 0, and the FSM returns to LOAD.
REQ-024 An addition on the COMMIT closing edge SHALL use the old ftw; the new ftw SHALL first be used on the following edge.
REQ-025 cfg_valid during COMMIT SHALL be ignored; the byte is not consumed, and the source holds it until cfg_ready=1.
REQ-026 cfg_abort=1 in LOAD SHALL clear byte_cnt and drop any byte presented in that cycle (abort wins over cfg_valid).
REQ-027 cfg_abort=1 in COMMIT SHALL be ignored; the commit completes.
REQ-028 Staging contents beyond byte_cnt SHALL be don't-care; only a complete word is ever committed.
REQ-029 ftw_busy SHALL be 1 when byte_cnt != 0 or the FSM is in COMMIT, and 0 otherwise.
REQ-030 Loading SHALL be independent of en and phase_clr; a word may be loaded while the accumulator is stopped.

Reset
REQ-031 Asserting rst SHALL immediately force: acc=0, ftw=0, staging=0, byte_cnt=0, FSM=LOAD, wrap=0.
REQ-032 While rst=1, outputs SHALL be phase_out=0, wrap=0, cfg_ready=1, ftw_busy=0.
REQ-033 rst asserted mid-load or mid-COMMIT SHALL discard the partial word, leaving ftw=0.

Verification
REQ-034 Reset; load bytes 00,00,01 with en=1 -> cfg_ready=0 for one cycle after the 3rd byte; phase_out then steps 0x00,0x01,0x02,... starting 2 edges after the 3rd byte is accepted.
REQ-035 Load 0x800000, en=1 -> phase_out alternates 0x80,0x00; wrap=1 in each cycle where phase_out returns to 0x00.
REQ-036 Load 0xFFFFFF from acc=0 -> acc goes 0xFFFFFF then 0xFFFFFE; wrap=0 then 1, then 1 every cycle after.
REQ-037 Send 2 bytes, then abort, then bytes 34,12,00 -> ftw=0x001234; ftw_busy drops after the commit.
REQ-038 Running at ftw=0x010000, assert en=1 with phase_clr=1 -> next phase_out=0x00 and wrap=0; at en=0, phase_out holds.
REQ-039 Assert rst asynchronously between edges during load byte 2 -> phase_out=0, cfg_ready=1, ftw_busy=0 with no clock edge; after release, acc stays 0 with en=1.
